// File: rtl/audio_tx_pkg.sv
// Shared types and constants for the I2S audio transmitter.
// Frame length is derived from the sample width via slotsPerFrame().
package audio_tx_pkg;

  typedef enum logic {
    TX_IDLE,
    TX_RUN
  } tx_state_t;

  localparam logic [7:0] UNDERRUN_COUNT_MAX = 8'hFF;

  function automatic int slotsPerFrame(int sampleWidth);
    return 2 * sampleWidth;
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Sample FIFO between the audio producers and the I2S serialiser.
// Full is registered from the next level so the producer sees it promptly.
module audio_sample_fifo #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [SAMPLE_WIDTH-1:0]         pushData,
  input  logic                            pop,
  output logic [SAMPLE_WIDTH-1:0]         popData,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH):0]     level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wrPtr;
  logic [PTR_W-1:0]        rdPtr;
  logic [LVL_W-1:0]        levelNext;
  logic                    pushOk;
  logic                    popOk;

  assign empty     = (level == '0);
  assign pushOk    = push && !full;
  assign popOk     = pop && !empty;
  assign popData   = mem[rdPtr];
  assign levelNext = level + LVL_W'(pushOk) - LVL_W'(popOk);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
      full  <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk)  rdPtr <= rdPtr + 1'b1;
      level <= levelNext;
      full  <= (levelNext == LVL_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/audio_i2s_transmitter.sv
// Mono-to-stereo I2S transmitter with sample FIFO and underrun tracking.
// Define AUDIO_TX_UNDERRUN_HOLD_EN to repeat the last sample on underrun.
module audio_i2s_transmitter
  import audio_tx_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int BCLK_DIV     = 16
) (
  input  logic                        clock_50Mhz,
  input  logic                        reset,
  input  logic [SAMPLE_WIDTH-1:0]     sample_data,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  input  logic                        tx_enable,
  output logic                        i2s_bclk,
  output logic                        i2s_lrclk,
  output logic                        i2s_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun,
  output logic [7:0]                  underrun_count
);

  localparam int SLOTS_PER_FRAME = slotsPerFrame(SAMPLE_WIDTH);
  localparam int SLOT_W = $clog2(SLOTS_PER_FRAME);
  localparam int DIV_W  = $clog2(BCLK_DIV);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS_PER_FRAME - 1);
  localparam logic [SLOT_W-1:0] HALF_SLOT = SLOT_W'(SAMPLE_WIDTH);
  localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(BCLK_DIV - 1);

  tx_state_t               state, stateNext;
  logic [DIV_W-1:0]        divCnt, divNext;
  logic [SLOT_W-1:0]       slot, slotNext;
  logic [SLOT_W-1:0]       newSlot, halfSlot;
  logic                    bclk, bclkNext;
  logic                    lrclk, lrNext;
  logic                    txData, dataNext;
  logic                    underrunQ, underrunNext;
  logic [7:0]              urCount, urCountNext;
  logic [SAMPLE_WIDTH-1:0] frameWord, frameNext;
  logic [SAMPLE_WIDTH-1:0] nextWord, nextWordNext;
  logic [SAMPLE_WIDTH-1:0] fifoData, shifted;
  logic                    fifoPop, fifoFull, fifoEmpty;

  audio_sample_fifo #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock_50Mhz),
    .rst     (reset),
    .push    (sample_valid),
    .pushData(sample_data),
    .pop     (fifoPop),
    .popData (fifoData),
    .full    (fifoFull),
    .empty   (fifoEmpty),
    .level   (fifo_level)
  );

  assign newSlot  = (slot == LAST_SLOT) ? '0 : slot + 1'b1;
  assign halfSlot = (newSlot >= HALF_SLOT) ? newSlot - HALF_SLOT
                                           : newSlot;
  // Slot h of a half carries bit W-h: the one-bit I2S delay.
  assign shifted  = frameWord >> (HALF_SLOT - halfSlot);

  always_comb begin
    stateNext    = state;
    divNext      = divCnt;
    slotNext     = slot;
    bclkNext     = bclk;
    lrNext       = lrclk;
    dataNext     = txData;
    frameNext    = frameWord;
    nextWordNext = nextWord;
    underrunNext = 1'b0;
    urCountNext  = urCount;
    fifoPop      = 1'b0;
    unique case (state)
      TX_IDLE: begin
        divNext  = '0;
        slotNext = '0;
        bclkNext = 1'b0;
        lrNext   = 1'b0;
        dataNext = 1'b0;
        if (tx_enable && !fifoEmpty) begin
          fifoPop   = 1'b1;
          frameNext = fifoData;
          stateNext = TX_RUN;
        end
      end
      TX_RUN: begin
        divNext = (divCnt == DIV_MAX) ? '0 : divCnt + 1'b1;
        if (divCnt == DIV_MAX) begin
          bclkNext = !bclk;
          if (bclk) begin
            slotNext = newSlot;
            lrNext   = (newSlot >= HALF_SLOT);
            dataNext = (halfSlot == '0) ? frameWord[0] : shifted[0];
            if (newSlot == LAST_SLOT) begin
              fifoPop = 1'b1;
              if (fifoEmpty) begin
                underrunNext = 1'b1;
                if (urCount != UNDERRUN_COUNT_MAX)
                  urCountNext = urCount + 1'b1;
`ifdef AUDIO_TX_UNDERRUN_HOLD_EN
                nextWordNext = frameWord;
`else
                nextWordNext = '0;
`endif
              end else begin
                nextWordNext = fifoData;
              end
            end
            if (newSlot == '0) begin
              frameNext = nextWord;
              if (!tx_enable) begin
                stateNext = TX_IDLE;
                lrNext    = 1'b0;
                dataNext  = 1'b0;
              end
            end
          end
        end
      end
      default: stateNext = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock_50Mhz or posedge reset) begin
    if (reset) begin
      state     <= TX_IDLE;
      divCnt    <= '0;
      slot      <= '0;
      bclk      <= 1'b0;
      lrclk     <= 1'b0;
      txData    <= 1'b0;
      frameWord <= '0;
      nextWord  <= '0;
      underrunQ <= 1'b0;
      urCount   <= '0;
    end else begin
      state     <= stateNext;
      divCnt    <= divNext;
      slot      <= slotNext;
      bclk      <= bclkNext;
      lrclk     <= lrNext;
      txData    <= dataNext;
      frameWord <= frameNext;
      nextWord  <= nextWordNext;
      underrunQ <= underrunNext;
      urCount   <= urCountNext;
    end
  end

  assign sample_ready   = !fifoFull;
  assign i2s_bclk       = bclk;
  assign i2s_lrclk      = lrclk;
  assign i2s_data       = txData;
  assign underrun       = underrunQ;
  assign underrun_count = urCount;

endmodule

// File: tb/tb_audio_i2s_transmitter.sv
// Randomized bench for audio_i2s_transmitter against a slot-level stream model.
// Uses a short BCLK divider so the saturation run stays brief.
module tb_audio_i2s_transmitter;

  localparam int SW    = 16;
  localparam int FD    = 8;
  localparam int DIV   = 3;
  localparam int SLOTS = 2 * SW;
  localparam int FRAME = 2 * DIV * SLOTS;
  localparam int LW    = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] sample_data;
  logic          sample_valid;
  logic          sample_ready;
  logic          tx_enable;
  logic          i2s_bclk;
  logic          i2s_lrclk;
  logic          i2s_data;
  logic [LW-1:0] fifo_level;
  logic          underrun;
  logic [7:0]    underrun_count;

  audio_i2s_transmitter #(
    .SAMPLE_WIDTH(SW),
    .FIFO_DEPTH  (FD),
    .BCLK_DIV    (DIV)
  ) dut (
    .clock_50Mhz   (clk),
    .reset         (rst),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .tx_enable     (tx_enable),
    .i2s_bclk      (i2s_bclk),
    .i2s_lrclk     (i2s_lrclk),
    .i2s_data      (i2s_data),
    .fifo_level    (fifo_level),
    .underrun      (underrun),
    .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            failures = 0;
  int            ncyc = 0;
  int            entryN = 0;
  int            urPulses = 0;
  int            urFirst = -1;
  logic          prevBclk = 1'b0;
  logic [1:0]    capQ[$];
  int            capCyc[$];
  logic [SW-1:0] pushed[$];
  logic [SW-1:0] frames[$];

  always @(negedge clk) begin
    ncyc++;
    if (i2s_bclk && !prevBclk) begin
      capQ.push_back({i2s_lrclk, i2s_data});
      capCyc.push_back(ncyc);
    end
    prevBclk = i2s_bclk;
    if (underrun) begin
      urPulses++;
      if (urFirst < 0) urFirst = ncyc;
    end
  end

  task automatic checkEq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pushWord(logic [SW-1:0] w);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = w;
    pushed.push_back(w);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic startTx();
    @(negedge clk);
    tx_enable = 1'b1;
    @(posedge clk);
    #1;
    entryN = ncyc + 1;
    capQ.delete();
    capCyc.delete();
    urPulses = 0;
    urFirst  = -1;
  endtask

  task automatic waitOff(int off);
    do begin
      @(posedge clk);
      #1;
    end while (ncyc + 1 < entryN + off);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tx_enable = 1'b0;
    pushed.delete();
  endtask

  // Words carried by each frame; an underrun frame is silence or a repeat.
  task automatic buildFrames(int nf);
    frames.delete();
    for (int f = 0; f < nf; f++) begin
      if (f < pushed.size()) frames.push_back(pushed[f]);
`ifdef AUDIO_TX_UNDERRUN_HOLD_EN
      else frames.push_back(frames[f-1]);
`else
      else frames.push_back('0);
`endif
    end
  endtask

  function automatic logic [1:0] expSlot(int k);
    int   f = k / SLOTS;
    int   s = k % SLOTS;
    int   h = s % SW;
    logic d;
    if (s == 0)      d = (f == 0) ? 1'b0 : frames[f-1][0];
    else if (h == 0) d = frames[f][0];
    else             d = frames[f][SW-h];
    return {(s >= SW), d};
  endfunction

  task automatic checkStream(int n);
    buildFrames(n / SLOTS + 1);
    checkEq("slotCount", capQ.size(), n);
    for (int k = 0; k < n && k < capQ.size(); k++)
      checkEq($sformatf("slot%0d", k), 32'(capQ[k]), 32'(expSlot(k)));
  endtask

  task automatic checkIdleOut(string tag);
    checkEq({tag, "Bclk"}, 32'(i2s_bclk), 0);
    checkEq({tag, "Lr"}, 32'(i2s_lrclk), 0);
    checkEq({tag, "Data"}, 32'(i2s_data), 0);
  endtask

  initial begin
    int acc;
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    tx_enable    = 1'b0;
    #12;
    checkIdleOut("rst");
    checkEq("rstReady", 32'(sample_ready), 1);
    checkEq("rstLevel", 32'(fifo_level), 0);
    checkEq("rstUr", 32'(underrun), 0);
    checkEq("rstUrCnt", 32'(underrun_count), 0);
    @(negedge clk);
    rst = 1'b0;

    // Backpressure: ten offers, only FD accepted
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = SW'($urandom);
      if (sample_ready) begin
        acc++;
        pushed.push_back(sample_data);
      end
    end
    @(negedge clk);
    sample_valid = 1'b0;
    checkEq("bpAccepted", acc, FD);
    checkEq("bpReady", 32'(sample_ready), 0);
    checkEq("bpLevel", 32'(fifo_level), FD);
    checkIdleOut("bp");

    // Stream eight frames of data, then underruns, stop mid frame 8
    startTx();
    waitOff(8 * FRAME + 10 * 2 * DIV + 1);
    tx_enable = 1'b0;
    waitOff(9 * FRAME + 4);
    checkIdleOut("stop");
    checkEq("stopLevel", 32'(fifo_level), 0);
    checkEq("stopReady", 32'(sample_ready), 1);
    checkEq("stopUrCnt", 32'(underrun_count), 2);
    waitOff(10 * FRAME);
    checkStream(9 * SLOTS);
    if (capCyc.size() > SLOTS) begin
      checkEq("firstRise", capCyc[0] - entryN, DIV);
      checkEq("framePeriod", capCyc[SLOTS] - capCyc[0], FRAME);
    end
    checkEq("urPulses", urPulses, 2);
    checkEq("urFirstAt", urFirst - entryN, 2 * DIV * (8 * SLOTS - 1));

    // Reset in the middle of a frame
    pushed.delete();
    for (int i = 0; i < 3; i++) pushWord(SW'($urandom));
    startTx();
    waitOff(20 * 2 * DIV + 2);
    checkEq("preRstLr", 32'(i2s_lrclk), 1);
    checkEq("preRstLevel", 32'(fifo_level), 2);
    #2 rst = 1'b1;
    #1;
    checkIdleOut("midRst");
    checkEq("midRstReady", 32'(sample_ready), 1);
    checkEq("midRstLevel", 32'(fifo_level), 0);
    checkEq("midRstUrCnt", 32'(underrun_count), 0);
    @(negedge clk);
    rst = 1'b0;
    tx_enable = 1'b0;
    pushed.delete();

    // Disable at slot 10: frame completes, one extra word fetched
    for (int i = 0; i < 4; i++) pushWord(SW'($urandom));
    startTx();
    waitOff(10 * 2 * DIV + 1);
    tx_enable = 1'b0;
    waitOff(FRAME - 1);
    checkEq("lastSlotLr", 32'(i2s_lrclk), 1);
    checkEq("lastSlotBclk", 32'(i2s_bclk), 1);
    waitOff(FRAME + 2);
    checkIdleOut("dis");
    checkEq("disLevel", 32'(fifo_level), 2);
    waitOff(3 * FRAME);
    checkStream(SLOTS);

    // Underrun counter saturation
    doReset();
    pushWord(SW'($urandom));
    startTx();
    waitOff(256 * FRAME + 1);
    checkEq("satNoWrap", 32'(underrun_count), 255);
    waitOff(300 * FRAME);
    checkEq("satUrCnt", 32'(underrun_count), 255);
    checkEq("satPulses", urPulses, 300);
    tx_enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
